// File: rtl/tpu_pkg.sv
// Shared constants and feeder FSM encoding for the TPU operand path.
package tpu_pkg;

  localparam int TPU_LANES  = 16;
  localparam int TPU_DATA_W = TPU_LANES * 8;
  localparam int TPU_PL_LEN = 144;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STREAM    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } feed_st_t;

endpackage

// File: rtl/feed_buf.sv
// 1W1R synchronous beat buffer with registered read; contents are never reset.
module feed_buf #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 144,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tpu_feeder.sv
// Streams an activation/weight tile to the systolic core as one contiguous burst.
// Optional macro TPU_FEED_PINGPONG_EN adds a second bank per buffer.
//
// state        | meaning
// ST_IDLE      | waiting for start, ready=1
// ST_STREAM    | issuing beats 0..K-1 from the active bank
// ST_WAIT_DONE | burst finished, waiting for core tpu_done
module tpu_feeder
  import tpu_pkg::*;
#(
  parameter int DEPTH  = TPU_PL_LEN,
  parameter int ADDR_W = 8,
  parameter int DATA_W = TPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_len,
  input  logic              start_bank,
  input  logic              tpu_done,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic              in_valid,
  output logic [DATA_W-1:0] mat_DI,
  output logic [DATA_W-1:0] wei_DI
);

`ifdef TPU_FEED_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  feed_st_t          state, state_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W-1:0] len_q, len_nxt;
  logic              bank_q, bank_nxt;
  logic              err_nxt, valid_nxt;
  logic              wbank, sbank, wr_block, wr_ok, len_ok;
  logic [DATA_W-1:0] act_q [NB];
  logic [DATA_W-1:0] wei_q [NB];
  logic [DATA_W-1:0] act_sel, wei_sel;

  assign busy  = (state != ST_IDLE);
  assign ready = (state == ST_IDLE);

`ifdef TPU_FEED_PINGPONG_EN
  assign wbank    = wr_bank;
  assign sbank    = start_bank;
  assign wr_block = busy && (wr_bank == bank_q);
  assign act_sel  = act_q[bank_q];
  assign wei_sel  = wei_q[bank_q];
`else
  logic unused_bank;
  assign unused_bank = wr_bank ^ start_bank;
  assign wbank    = 1'b0;
  assign sbank    = 1'b0;
  assign wr_block = busy;
  assign act_sel  = act_q[0];
  assign wei_sel  = wei_q[0];
`endif

  assign wr_ok  = wr_en && (int'(wr_addr) < DEPTH) && !wr_block;
  assign len_ok = (start_len != '0) && (int'(start_len) <= DEPTH);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    feed_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_act (
      .clk     (clk),
      .wr_en   (wr_ok && !wr_sel && (wbank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (state == ST_STREAM),
      .rd_addr (rd_ptr),
      .rd_data (act_q[b])
    );
    feed_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wei (
      .clk     (clk),
      .wr_en   (wr_ok && wr_sel && (wbank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (state == ST_STREAM),
      .rd_addr (rd_ptr),
      .rd_data (wei_q[b])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rd_ptr   <= '0;
      len_q    <= '0;
      bank_q   <= 1'b0;
      in_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_ptr   <= rd_ptr_nxt;
      len_q    <= len_nxt;
      bank_q   <= bank_nxt;
      in_valid <= valid_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    len_nxt    = len_q;
    bank_nxt   = bank_q;
    valid_nxt  = 1'b0;
    err_nxt    = wr_en && !wr_ok;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_nxt  = ST_STREAM;
            rd_ptr_nxt = '0;
            len_nxt    = start_len;
            bank_nxt   = sbank;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        valid_nxt  = 1'b1;
        rd_ptr_nxt = rd_ptr + ADDR_W'(1);
        if (rd_ptr == len_q - ADDR_W'(1)) state_nxt = ST_WAIT_DONE;
        if (start) err_nxt = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (start) err_nxt = 1'b1;
        if (tpu_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Gating with the registered valid keeps the beat bus at zero outside a burst
  // and clears it asynchronously with rst.
  assign mat_DI = in_valid ? act_sel : '0;
  assign wei_DI = in_valid ? wei_sel : '0;

endmodule
